// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, opcode constants and FSM state type for the ALU op sequencer
package alu_seq_pkg;
  localparam logic [3:0] OP_0000 = 4'h0;
  localparam logic [3:0] OP_0001 = 4'h1;
  localparam logic [3:0] OP_0010 = 4'h2;
  localparam logic [3:0] OP_0011 = 4'h3;
  localparam logic [3:0] OP_0100 = 4'h4;
  localparam logic [3:0] OP_0101 = 4'h5;
  localparam logic [3:0] OP_0110 = 4'h6;
  localparam logic [3:0] OP_0111 = 4'h7;
  localparam logic [3:0] OP_1000 = 4'h8;
  localparam logic [3:0] OP_1001 = 4'h9;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_OPCODE_MAX = int'(OP_1001);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/alu_seq_wait_ctr.sv
// alu_seq_wait_ctr: loadable settle down-counter; ports clk, rst_n, load/load_val (arm), en (count), done (pulse while en and count==1)
module alu_seq_wait_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != 4'd0) cnt <= cnt - 4'd1;
  assign done = en && cnt == 4'd1;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front end for an external ALU (req_* in, alu_* drive/capture, rsp_* out, acc chaining); optional flag_mismatch port with ALU_SEQ_FLAGCHECK_EN
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 1,
  parameter int OPCODE_MAX = DEF_OPCODE_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_use_acc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_s,
  output logic             rsp_z,
  output logic             rsp_p,
  output logic             rsp_err,
`ifdef ALU_SEQ_FLAGCHECK_EN
  output logic             flag_mismatch,
`endif
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_s,
  input  logic             alu_z,
  input  logic             alu_p,
  output logic [WIDTH-1:0] acc
);
  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);
  localparam logic [3:0] OPMAX = 4'(OPCODE_MAX);
  state_t state, state_nx;
  logic accept, illegal, done;
  assign accept = req_valid && req_ready;
  assign illegal = req_opcode > OPMAX;
  alu_seq_wait_ctr u_ctr (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept && !illegal),
    .load_val(SETTLE),
    .en(state == WAIT),
    .done(done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (accept ? (illegal ? RESP : WAIT) : IDLE) :
               state == WAIT ? (done ? RESP : WAIT) :
               (rsp_ready ? IDLE : RESP);
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_opcode <= '0;
      alu_a <= '0;
      alu_b <= '0;
      rsp_result <= '0;
      {rsp_carry, rsp_s, rsp_z, rsp_p, rsp_err} <= '0;
      acc <= '0;
`ifdef ALU_SEQ_FLAGCHECK_EN
      flag_mismatch <= 1'b0;
`endif
    end else if (accept && !illegal) begin
      alu_opcode <= req_opcode;
      alu_a <= req_use_acc ? acc : req_a;
      alu_b <= req_b;
    end else if (accept) begin
      rsp_result <= '0;
      {rsp_carry, rsp_s, rsp_z, rsp_p, rsp_err} <= 5'b00001;
`ifdef ALU_SEQ_FLAGCHECK_EN
      flag_mismatch <= 1'b0;
`endif
    end else if (done) begin
      rsp_result <= alu_result;
      {rsp_carry, rsp_s, rsp_z, rsp_p, rsp_err} <= {alu_carry, alu_s, alu_z, alu_p, 1'b0};
      acc <= alu_result;
`ifdef ALU_SEQ_FLAGCHECK_EN
      flag_mismatch <= (alu_z != (alu_result == '0)) || (alu_s != alu_result[WIDTH-1]);
`endif
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table-driven scoreboard bench for alu_op_sequencer (SETTLE 1 and SETTLE 3 instances, stub ALU)
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, rst3_n, req_valid, req_valid3, rsp_ready, rsp_ready3, req_use_acc;
  logic [3:0] req_opcode;
  logic [7:0] req_a, req_b, alu_result;
  logic alu_carry, alu_s, alu_z, alu_p;
  logic req_ready, rsp_valid, rsp_carry, rsp_s, rsp_z, rsp_p, rsp_err;
  logic [7:0] rsp_result, alu_a, alu_b, acc;
  logic [3:0] alu_opcode;
  logic req_ready3, rsp_valid3, rsp_carry3, rsp_s3, rsp_z3, rsp_p3, rsp_err3;
  logic [7:0] rsp_result3, alu_a3, alu_b3, acc3;
  logic [3:0] alu_opcode3;
`ifdef ALU_SEQ_FLAGCHECK_EN
  logic flag_mismatch, flag_mismatch3;
`endif
  alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1), .OPCODE_MAX(9)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_s(rsp_s), .rsp_z(rsp_z), .rsp_p(rsp_p), .rsp_err(rsp_err),
`ifdef ALU_SEQ_FLAGCHECK_EN
    .flag_mismatch(flag_mismatch),
`endif
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_s(alu_s), .alu_z(alu_z), .alu_p(alu_p), .acc(acc)
  );
  alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(3), .OPCODE_MAX(9)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_carry(rsp_carry3), .rsp_s(rsp_s3), .rsp_z(rsp_z3), .rsp_p(rsp_p3), .rsp_err(rsp_err3),
`ifdef ALU_SEQ_FLAGCHECK_EN
    .flag_mismatch(flag_mismatch3),
`endif
    .alu_opcode(alu_opcode3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_s(alu_s), .alu_z(alu_z), .alu_p(alu_p), .acc(acc3)
  );
  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b;
    logic ua;
    logic [7:0] sr;
    logic sc, ss, sz, sp;
    logic [3:0] eop;
    logic [7:0] ea, eb;
    logic ee;
    logic [7:0] eacc;
  } vec_t;
  typedef struct {
    logic [7:0] r;
    logic c, s, z, p, e;
    logic [7:0] acc;
    logic fm;
  } exp_t;
  vec_t vt[8];
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic run_op(input vec_t v);
    exp_t x;
    int lat;
    logic ill;
    ill = v.op > 4'd9;
    x.e = ill;
    x.r = ill ? 8'h00 : v.sr;
    x.c = !ill && v.sc;
    x.s = !ill && v.ss;
    x.z = !ill && v.sz;
    x.p = !ill && v.sp;
    x.acc = v.eacc;
    x.fm = !ill && ((v.sz != (v.sr == 8'h00)) || (v.ss != v.sr[7]));
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_opcode = v.op; req_a = v.a; req_b = v.b; req_use_acc = v.ua;
    alu_result = v.sr; alu_carry = v.sc; alu_s = v.ss; alu_z = v.sz; alu_p = v.sp;
    req_valid = 1'b1;
    sb.push_back(x);
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_busy", req_ready, 0);
    check("alu_opcode", alu_opcode, v.eop);
    check("alu_a", alu_a, v.ea);
    check("alu_b", alu_b, v.eb);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", lat, ill ? 0 : 1);
    check("req_ready_resp", req_ready, 0);
    x = sb.pop_front();
    check("rsp_result", rsp_result, x.r);
    check("rsp_flags", {rsp_carry, rsp_s, rsp_z, rsp_p}, {x.c, x.s, x.z, x.p});
    check("rsp_err", rsp_err, x.e);
    check("acc", acc, x.acc);
`ifdef ALU_SEQ_FLAGCHECK_EN
    check("flag_mismatch", flag_mismatch, x.fm);
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_done", rsp_valid, 0);
    check("req_ready_back", req_ready, 1);
  endtask
  initial begin
    int lat;
    rst_n = 0; rst3_n = 0; req_valid = 0; req_valid3 = 0; rsp_ready = 0; rsp_ready3 = 0;
    req_use_acc = 0; req_opcode = 0; req_a = 0; req_b = 0;
    alu_result = 0; alu_carry = 0; alu_s = 0; alu_z = 0; alu_p = 0;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_acc", acc, 0);
    check("rst_alu", {alu_opcode, alu_a, alu_b}, 0);
    check("rst_rsp", {rsp_result, rsp_carry, rsp_s, rsp_z, rsp_p, rsp_err}, 0);
    rst_n = 1; rst3_n = 1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    vt[0] = '{4'h0, 8'h9A, 8'hAA, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 8'h9A, 8'hAA, 1'b0, 8'h44};
    vt[1] = '{4'h1, 8'hFF, 8'h01, 1'b1, 8'h45, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 8'h44, 8'h01, 1'b0, 8'h45};
    vt[2] = '{4'hC, 8'h11, 8'h22, 1'b0, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 8'h44, 8'h01, 1'b1, 8'h45};
    vt[3] = '{4'h9, 8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h9, 8'h80, 8'h7F, 1'b0, 8'hFF};
    vt[4] = '{4'hA, 8'h01, 8'h02, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 8'h80, 8'h7F, 1'b1, 8'hFF};
    vt[5] = '{4'h2, 8'h00, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 8'hFF, 8'h01, 1'b0, 8'h00};
    vt[6] = '{4'h0, 8'h01, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h01, 8'h02, 1'b0, 8'h00};
    vt[7] = '{4'h0, 8'h03, 8'h04, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h03, 8'h04, 1'b0, 8'h80};
    for (int i = 0; i < 8; i++) run_op(vt[i]);
    @(negedge clk);
    req_opcode = 4'h3; req_a = 8'h12; req_b = 8'h34; req_use_acc = 0;
    alu_result = 8'h46; alu_carry = 0; alu_s = 0; alu_z = 0; alu_p = 1;
    req_valid = 1;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 2);
    req_a = 8'h99;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_req_ready", req_ready, 0);
      check("bp_rsp", {rsp_result, rsp_carry, rsp_s, rsp_z, rsp_p, rsp_err}, {8'h46, 5'b00010});
      check("bp_alu_a", alu_a, 8'h12);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0; req_valid = 0;
    check("bp_req_ready_after", req_ready, 1);
    check("bp_rsp_valid_after", rsp_valid, 0);
    check("bp_rsp_hold", rsp_result, 8'h46);
    check("bp_acc", acc, 8'h46);
    @(negedge clk);
    req_opcode = 4'h0; req_a = 8'h5A; req_b = 8'h01; req_use_acc = 0;
    alu_result = 8'h5B; alu_carry = 0; alu_s = 0; alu_z = 0; alu_p = 1;
    req_valid3 = 1;
    @(negedge clk);
    req_valid3 = 0;
    check("s3_alu_a", alu_a3, 8'h5A);
    lat = 0;
    while (!rsp_valid3 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("s3_latency", lat, 3);
    check("s3_result", rsp_result3, 8'h5B);
    check("s3_acc", acc3, 8'h5B);
    rsp_ready3 = 1;
    @(negedge clk);
    rsp_ready3 = 0;
    check("s3_req_ready", req_ready3, 1);
    req_a = 8'h21;
    req_valid3 = 1;
    @(negedge clk);
    req_valid3 = 0;
    @(negedge clk);
    check("s3_in_wait", {req_ready3, rsp_valid3}, 2'b00);
    rst3_n = 0;
    #1;
    check("s3_rst_valid", rsp_valid3, 0);
    check("s3_rst_acc", acc3, 0);
    check("s3_rst_alu_a", alu_a3, 0);
    @(negedge clk);
    rst3_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s3_post_rst_valid", rsp_valid3, 0);
      check("s3_post_rst_ready", req_ready3, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
